// File: rtl/blackjack_round_controller_if.sv
// rtl/blackjack_round_controller_if.sv - command, deck and display signals of the blackjack round controller
//
// Purpose: bundles every non-clock signal of blackjack_round_controller.
// Ports (signals):
//   i_dealButtonPushed, i_ready, i_command    command source (buttons / player input)
//   o_turnIndicator                            player turn lamp
//   o_cardReq, o_cardToDealer, i_cardValid,
//   i_cardValue                                deck req/valid card handshake
//   o_playerTotal, o_dealerTotal, o_result,
//   o_roundDone                                display outputs
// Modports: master = controller side, slave = environment side.

`ifndef GAME_COMMAND_DEFS
`define GAME_COMMAND_DEFS
`define gameCommand logic [1:0]
`define COMMAND_NONE  2'd0
`define COMMAND_HIT   2'd1
`define COMMAND_STAND 2'd2
`endif

interface blackjack_round_controller_if;
    logic        i_dealButtonPushed;
    logic        i_ready;
    `gameCommand i_command;
    logic        o_turnIndicator;
    logic        o_cardReq;
    logic        o_cardToDealer;
    logic        i_cardValid;
    logic [3:0]  i_cardValue;
    logic [4:0]  o_playerTotal;
    logic [4:0]  o_dealerTotal;
    logic [1:0]  o_result;
    logic        o_roundDone;

    modport master (
        input  i_dealButtonPushed, i_ready, i_command, i_cardValid, i_cardValue,
        output o_turnIndicator, o_cardReq, o_cardToDealer,
               o_playerTotal, o_dealerTotal, o_result, o_roundDone
    );

    modport slave (
        output i_dealButtonPushed, i_ready, i_command, i_cardValid, i_cardValue,
        input  o_turnIndicator, o_cardReq, o_cardToDealer,
               o_playerTotal, o_dealerTotal, o_result, o_roundDone
    );
endinterface

// File: rtl/blackjack_round_controller.sv
// rtl/blackjack_round_controller.sv - sequences one blackjack round: deal, player turn, dealer policy, result
//
// Purpose: deals four cards, grants the player turn, runs the dealer
// hit-below-17 policy with display pacing, then latches the round result.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      blackjack_round_controller_if.master (commands, deck handshake, display)
// Parameters:
//   DEALER_DELAY  cycles waited before each dealer draw decision (>= 1)
//   CNT_W         width of the dealer delay counter

module blackjack_round_controller #(
    parameter int DEALER_DELAY = 25000000,
    parameter int CNT_W        = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    blackjack_round_controller_if.master   bus
);

    localparam logic [1:0]       CMD_HIT   = `COMMAND_HIT;
    localparam logic [1:0]       CMD_STAND = `COMMAND_STAND;
    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(DEALER_DELAY);

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_WIN  = 2'd1;
    localparam logic [1:0] RES_LOSE = 2'd2;
    localparam logic [1:0] RES_PUSH = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        PLAYER_TURN,
        PLAYER_HIT,
        DEALER_WAIT,
        DEALER_HIT,
        RESOLVE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       p_raw_q, p_raw_d;
    logic             p_ace_q, p_ace_d;
    logic [4:0]       d_raw_q, d_raw_d;
    logic             d_ace_q, d_ace_d;
    logic [4:0]       p_total_q, p_total_d;
    logic [4:0]       d_total_q, d_total_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       result_q, result_d;
    logic             card_req_q, card_req_d;
    logic             to_dealer_q, to_dealer_d;
    logic             turn_q, turn_d;
    logic             done_q, done_d;

    logic [3:0]       card_v;
    logic             xfer;
    logic             card_ace;
    logic [4:0]       p_add, d_add;

    // An ace counts 11 only while that keeps the hand at or under 21.
    function automatic logic [4:0] best_total(input logic [4:0] raw, input logic ace);
        return (ace && (raw <= 5'd11)) ? raw + 5'd10 : raw;
    endfunction

    always_comb begin
        card_v      = (bus.i_cardValue == 4'd0 || bus.i_cardValue > 4'd10) ? 4'd10 : bus.i_cardValue;
        // card_req_q is only ever high in a requesting state, so a stray
        // valid with no request outstanding never transfers.
        xfer        = card_req_q && bus.i_cardValid;
        card_ace    = (card_v == 4'd1);
        p_add       = p_raw_q + {1'b0, card_v};
        d_add       = d_raw_q + {1'b0, card_v};

        state_d     = state_q;
        p_raw_d     = p_raw_q;
        p_ace_d     = p_ace_q;
        d_raw_d     = d_raw_q;
        d_ace_d     = d_ace_q;
        cnt_d       = cnt_q;
        result_d    = result_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.i_dealButtonPushed) begin
                    p_raw_d  = 5'd0;
                    p_ace_d  = 1'b0;
                    d_raw_d  = 5'd0;
                    d_ace_d  = 1'b0;
                    result_d = RES_NONE;
                    state_d  = DEAL_P1;
                end
            end
            DEAL_P1, DEAL_P2: begin
                if (xfer) begin
                    p_raw_d = p_add;
                    p_ace_d = p_ace_q | card_ace;
                    state_d = (state_q == DEAL_P1) ? DEAL_D1 : DEAL_D2;
                end
            end
            DEAL_D1, DEAL_D2: begin
                if (xfer) begin
                    d_raw_d = d_add;
                    d_ace_d = d_ace_q | card_ace;
                    state_d = (state_q == DEAL_D1) ? DEAL_P2 : PLAYER_TURN;
                end
            end
            PLAYER_TURN: begin
                if (p_total_q == 5'd21) begin
                    state_d = DEALER_WAIT;
                    cnt_d   = DELAY_LD;
                end else if (bus.i_ready) begin
                    if (bus.i_command == CMD_HIT) begin
                        state_d = PLAYER_HIT;
                    end else if (bus.i_command == CMD_STAND) begin
                        state_d = DEALER_WAIT;
                        cnt_d   = DELAY_LD;
                    end
                end
            end
            PLAYER_HIT: begin
                if (xfer) begin
                    p_raw_d = p_add;
                    p_ace_d = p_ace_q | card_ace;
                    state_d = (best_total(p_add, p_ace_q | card_ace) > 5'd21) ? RESOLVE : PLAYER_TURN;
                end
            end
            DEALER_WAIT: begin
                // Counter was loaded on entry, so this state spans DELAY+1 cycles.
                if (cnt_q == '0) begin
                    state_d = (d_total_q < 5'd17) ? DEALER_HIT : RESOLVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DEALER_HIT: begin
                if (xfer) begin
                    d_raw_d = d_add;
                    d_ace_d = d_ace_q | card_ace;
                    state_d = DEALER_WAIT;
                    cnt_d   = DELAY_LD;
                end
            end
            RESOLVE: begin
                if (p_total_q > 5'd21)           result_d = RES_LOSE;
                else if (d_total_q > 5'd21)      result_d = RES_WIN;
                else if (p_total_q > d_total_q)  result_d = RES_WIN;
                else if (p_total_q < d_total_q)  result_d = RES_LOSE;
                else                             result_d = RES_PUSH;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so a request is raised
        // the cycle a requesting state is entered (no bubble between cards).
        card_req_d  = (state_d == DEAL_P1) || (state_d == DEAL_D1) ||
                      (state_d == DEAL_P2) || (state_d == DEAL_D2) ||
                      (state_d == PLAYER_HIT) || (state_d == DEALER_HIT);
        to_dealer_d = (state_d == DEAL_D1) || (state_d == DEAL_D2) || (state_d == DEALER_HIT);
        p_total_d   = best_total(p_raw_d, p_ace_d);
        d_total_d   = best_total(d_raw_d, d_ace_d);
        turn_d      = (state_d == PLAYER_TURN) && (p_total_d != 5'd21);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            p_raw_q     <= 5'd0;
            p_ace_q     <= 1'b0;
            d_raw_q     <= 5'd0;
            d_ace_q     <= 1'b0;
            p_total_q   <= 5'd0;
            d_total_q   <= 5'd0;
            cnt_q       <= '0;
            result_q    <= RES_NONE;
            card_req_q  <= 1'b0;
            to_dealer_q <= 1'b0;
            turn_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_raw_q     <= p_raw_d;
            p_ace_q     <= p_ace_d;
            d_raw_q     <= d_raw_d;
            d_ace_q     <= d_ace_d;
            p_total_q   <= p_total_d;
            d_total_q   <= d_total_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            card_req_q  <= card_req_d;
            to_dealer_q <= to_dealer_d;
            turn_q      <= turn_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_turnIndicator = turn_q;
    assign bus.o_cardReq       = card_req_q;
    assign bus.o_cardToDealer  = to_dealer_q;
    assign bus.o_playerTotal   = p_total_q;
    assign bus.o_dealerTotal   = d_total_q;
    assign bus.o_result        = result_q;
    assign bus.o_roundDone     = done_q;

endmodule

// File: tb/tb_blackjack_round_controller.sv
// tb/tb_blackjack_round_controller.sv - directed self-checking bench for blackjack_round_controller

module tb_blackjack_round_controller;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_HIT   = 2'd1;
    localparam logic [1:0] CMD_STAND = 2'd2;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    blackjack_round_controller_if bus ();

    blackjack_round_controller #(
        .DEALER_DELAY (2),
        .CNT_W        (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic deal();
        bus.i_dealButtonPushed = 1'b1;
        step();
        bus.i_dealButtonPushed = 1'b0;
    endtask

    task automatic give_card(input string tag, input logic [3:0] v, input int hold);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_req_held"}, bus.o_cardReq, 1);
            step();
        end
        chk({tag, "_req"}, bus.o_cardReq, 1);
        bus.i_cardValid = 1'b1;
        bus.i_cardValue = v;
        step();
        bus.i_cardValid = 1'b0;
        bus.i_cardValue = 4'd0;
    endtask

    task automatic cmd(input logic [1:0] c, input logic with_deal);
        bus.i_ready            = 1'b1;
        bus.i_command          = c;
        bus.i_dealButtonPushed = with_deal;
        step();
        bus.i_ready            = 1'b0;
        bus.i_command          = CMD_NONE;
        bus.i_dealButtonPushed = 1'b0;
    endtask

    // Counts cycles until o_roundDone, noting any request or turn grant seen.
    task automatic wait_done(output int n, output logic req_seen, output logic turn_seen);
        n = 0;
        req_seen = 1'b0;
        turn_seen = 1'b0;
        while (!bus.o_roundDone && n < 100) begin
            req_seen  = req_seen  | bus.o_cardReq;
            turn_seen = turn_seen | bus.o_turnIndicator;
            step();
            n++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_turn"},  bus.o_turnIndicator, 0);
        chk({tag, "_req"},   bus.o_cardReq, 0);
        chk({tag, "_todlr"}, bus.o_cardToDealer, 0);
        chk({tag, "_ptot"},  bus.o_playerTotal, 0);
        chk({tag, "_dtot"},  bus.o_dealerTotal, 0);
        chk({tag, "_res"},   bus.o_result, 0);
        chk({tag, "_done"},  bus.o_roundDone, 0);
    endtask

    int   n;
    logic req_seen;
    logic turn_seen;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.i_dealButtonPushed = 1'b0;
        bus.i_ready     = 1'b0;
        bus.i_command   = CMD_NONE;
        bus.i_cardValid = 1'b0;
        bus.i_cardValue = 4'd0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Stray valid in IDLE is ignored.
        bus.i_cardValid = 1'b1;
        bus.i_cardValue = 4'd9;
        step();
        bus.i_cardValid = 1'b0;
        chk_all_zero("idle_stray");

        // ---- Basic round: 10,9,7,8, STAND -> push 17/17 ----
        deal();
        chk("b_req_n1", bus.o_cardReq, 1);
        chk("b_dest_p1", bus.o_cardToDealer, 0);
        give_card("b_p1", 4'd10, 0);
        chk("b_ptot1", bus.o_playerTotal, 10);
        chk("b_dest_d1", bus.o_cardToDealer, 1);
        give_card("b_d1", 4'd9, 0);
        chk("b_dtot1", bus.o_dealerTotal, 9);
        chk("b_dest_p2", bus.o_cardToDealer, 0);
        give_card("b_p2", 4'd7, 0);
        give_card("b_d2", 4'd8, 0);
        chk("b_ptot", bus.o_playerTotal, 17);
        chk("b_dtot", bus.o_dealerTotal, 17);
        chk("b_req_off", bus.o_cardReq, 0);
        chk("b_turn_on", bus.o_turnIndicator, 1);
        cmd(CMD_STAND, 1'b0);
        chk("b_turn_off", bus.o_turnIndicator, 0);
        wait_done(n, req_seen, turn_seen);
        chk("b_done_lat", n, 4);
        chk("b_no_draw", req_seen, 0);
        chk("b_result", bus.o_result, 3);
        chk("b_done", bus.o_roundDone, 1);

        // ---- Player bust: 10,5,6,6, HIT 10 ----
        deal();
        chk("x_res_clr", bus.o_result, 0);
        chk("x_done_clr", bus.o_roundDone, 0);
        chk("x_ptot_clr", bus.o_playerTotal, 0);
        give_card("x_p1", 4'd10, 0);
        give_card("x_d1", 4'd5, 0);
        give_card("x_p2", 4'd6, 0);
        give_card("x_d2", 4'd6, 0);
        chk("x_ptot16", bus.o_playerTotal, 16);
        chk("x_turn", bus.o_turnIndicator, 1);
        cmd(CMD_HIT, 1'b0);
        chk("x_turn_off", bus.o_turnIndicator, 0);
        chk("x_hit_req", bus.o_cardReq, 1);
        chk("x_hit_dest", bus.o_cardToDealer, 0);
        give_card("x_hit", 4'd10, 0);
        chk("x_ptot26", bus.o_playerTotal, 26);
        chk("x_req_off", bus.o_cardReq, 0);
        wait_done(n, req_seen, turn_seen);
        chk("x_done_lat", n, 1);
        chk("x_no_req", req_seen, 0);
        chk("x_result", bus.o_result, 2);
        chk("x_dtot", bus.o_dealerTotal, 11);

        // ---- Soft ace blackjack: P 1,10  D 10,7 ----
        deal();
        give_card("s_p1", 4'd1, 0);
        chk("s_soft11", bus.o_playerTotal, 11);
        give_card("s_d1", 4'd10, 0);
        give_card("s_p2", 4'd10, 0);
        chk("s_ptot21", bus.o_playerTotal, 21);
        give_card("s_d2", 4'd7, 0);
        chk("s_turn_t1", bus.o_turnIndicator, 0);
        wait_done(n, req_seen, turn_seen);
        chk("s_done_lat", n, 5);
        chk("s_turn_never", turn_seen, 0);
        chk("s_no_draw", req_seen, 0);
        chk("s_dtot", bus.o_dealerTotal, 17);
        chk("s_result", bus.o_result, 1);

        // ---- Dealer draws on 16, with ignored inputs in PLAYER_TURN ----
        deal();
        give_card("h_p1", 4'd10, 0);
        give_card("h_d1", 4'd10, 0);
        give_card("h_p2", 4'd9, 0);
        give_card("h_d2", 4'd6, 0);
        chk("h_turn", bus.o_turnIndicator, 1);
        bus.i_cardValid = 1'b1;
        bus.i_cardValue = 4'd5;
        step();
        bus.i_cardValid = 1'b0;
        chk("h_stray_ptot", bus.o_playerTotal, 19);
        chk("h_stray_dtot", bus.o_dealerTotal, 16);
        chk("h_stray_req", bus.o_cardReq, 0);
        cmd(CMD_NONE, 1'b0);
        chk("h_none_turn", bus.o_turnIndicator, 1);
        chk("h_none_req", bus.o_cardReq, 0);
        deal();
        chk("h_deal_turn", bus.o_turnIndicator, 1);
        chk("h_deal_req", bus.o_cardReq, 0);
        chk("h_deal_ptot", bus.o_playerTotal, 19);
        cmd(CMD_STAND, 1'b1);
        chk("h_stand_turn", bus.o_turnIndicator, 0);
        chk("h_stand_req", bus.o_cardReq, 0);
        n = 0;
        while (!bus.o_cardReq && n < 100) begin
            step();
            n++;
        end
        chk("h_wait_len", n, 3);
        chk("h_dlr_dest", bus.o_cardToDealer, 1);
        give_card("h_dhit", 4'd10, 5);
        chk("h_dtot26", bus.o_dealerTotal, 26);
        chk("h_req_off", bus.o_cardReq, 0);
        wait_done(n, req_seen, turn_seen);
        chk("h_done_lat", n, 4);
        chk("h_no_redraw", req_seen, 0);
        chk("h_result", bus.o_result, 1);

        // ---- Reset mid-handshake in DEAL_D1 ----
        deal();
        give_card("r_p1", 4'd10, 0);
        chk("r_d1_req", bus.o_cardReq, 1);
        chk("r_d1_dest", bus.o_cardToDealer, 1);
        rst_n = 1'b0;
        bus.i_cardValid = 1'b1;
        bus.i_cardValue = 4'd7;
        #1;
        chk_all_zero("r_async");
        step();
        step();
        rst_n = 1'b1;
        step();
        bus.i_cardValid = 1'b0;
        bus.i_cardValue = 4'd0;
        chk_all_zero("r_late_valid");
        step();
        chk("r_idle_req", bus.o_cardReq, 0);
        deal();
        chk("r_redeal_req", bus.o_cardReq, 1);
        chk("r_redeal_dest", bus.o_cardToDealer, 0);
        chk("r_redeal_ptot", bus.o_playerTotal, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blackjack_round_controller.md
# blackjack_round_controller

Sequences one round of blackjack. It starts the round on the deal button, requests cards from the deck block with a req/valid handshake, and grants the turn to the player input block. It runs the dealer's fixed hit-below-17 policy, then compares totals and latches a result. It sits between the debounced button block (command source), the deck/card generator (card source) and the display logic (totals and result).

## Interface
Parameters:
- DEALER_DELAY, default 25000000: clock cycles the controller waits before each dealer draw request (display pacing). Minimum legal value is 1.
- CNT_W, default 32: width of the dealer delay counter.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_dealButtonPushed  in  1  one-cycle pulse requesting a new deal.
- i_ready  in  1  player input valid; one-cycle pulse.
- i_command  in  `gameCommand  player command, qualified by i_ready; uses COMMAND_NONE, COMMAND_HIT and COMMAND_STAND.
- o_turnIndicator  out  1  high only while waiting for a player command.
- o_cardReq  out  1  card request to the deck.
- o_cardToDealer  out  1  destination of the requested card: 0 = player, 1 = dealer. Stable while o_cardReq is high.
- i_cardValid  in  1  deck response; the card transfers on a cycle with o_cardReq && i_cardValid.
- i_cardValue  in  4  card rank value, 1..10; ace = 1; face cards = 10.
- o_playerTotal  out  5  player best total (soft-ace adjusted).
- o_dealerTotal  out  5  dealer best total (soft-ace adjusted).
- o_result  out  2  0 = none, 1 = player win, 2 = player lose, 3 = push.
- o_roundDone  out  1  high in state DONE.

## Operation
- Per hand, the controller keeps a raw sum (5 bits) and an ace flag.
  - Best total = raw + 10 if the ace flag is set and raw ≤ 11; otherwise best total = raw.
  - The maximum raw value reachable is 30, so 5 bits never wrap.
- A card with i_cardValue of 0 or greater than 10 is treated as 10.
- State machine:
  - IDLE: all outputs at their reset values. i_dealButtonPushed clears both hands and goes to DEAL_P1.
  - DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2: each state raises o_cardReq with the matching destination (player, dealer, player, dealer). On transfer, the controller adds the card and moves to the next state. After DEAL_D2 it goes to PLAYER_TURN.
  - PLAYER_TURN:
    - If the player best total is 21, the controller goes directly to DEALER_WAIT.
    - Otherwise o_turnIndicator = 1.
    - i_ready with HIT goes to PLAYER_HIT.
    - i_ready with STAND goes to DEALER_WAIT.
    - i_ready with NONE is ignored.
  - PLAYER_HIT: requests a card to the player and adds it on transfer.
    - Player best total > 21: go to RESOLVE (bust).
    - Otherwise: go to PLAYER_TURN.
  - DEALER_WAIT: loads the counter with DEALER_DELAY and counts down.
    - On reaching 0, if the dealer best total < 17, go to DEALER_HIT; otherwise go to RESOLVE.
    - The dealer stands on soft 17.
  - DEALER_HIT: requests a card to the dealer, adds it on transfer, then goes to DEALER_WAIT.
  - RESOLVE: one cycle. It writes o_result and goes to DONE. Result rules, in order:
    - Player > 21: lose.
    - Else dealer > 21: win.
    - Else player > dealer: win.
    - Else player < dealer: lose.
    - Else: push.
  - DONE: holds the totals and the result.
    - i_dealButtonPushed clears the hands and o_result, and goes to DEAL_P1.
    - A deal pulse in any state other than IDLE or DONE is ignored.
- Reset (asynchronous, in any state including mid-handshake):
  - State returns to IDLE and all outputs go to 0.
  - Totals clear.
  - An outstanding card request is dropped, and a late i_cardValid is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Deal pulse in IDLE at cycle N: o_cardReq = 1 at N+1.
- Card handshake:
  - o_cardReq stays high until the transfer cycle T.
  - At T+1 the updated total is visible and the next state is active.
  - In the deal states, o_cardReq for the next card is high at T+1 (one request per card, no bubble).
  - The controller tolerates i_cardValid while o_cardReq is low and ignores it.
- Player command: i_ready at cycle C in PLAYER_TURN drops o_turnIndicator at C+1. For a HIT, o_cardReq is high at C+1.
- Dealer pacing: DEALER_WAIT lasts DEALER_DELAY+1 cycles, including the load cycle.
- If i_ready and i_dealButtonPushed arrive in the same cycle, only the input valid in the current state is used.
- o_result and o_roundDone become valid two cycles after the deciding card transfers, or after the dealer stands.

## Test plan
- Basic round, DEALER_DELAY=2:
  - Cards P=10, D=9, P=7, D=8; player STAND.
  - Required: totals 17/17, dealer stands, o_result = 3 (push), o_roundDone = 1.
- Player bust:
  - Cards 10, 5, 6, 6; then HIT with card 10.
  - Required: player total 26, no further card requests, o_result = 2 (lose), and DEALER_WAIT is never entered.
- Soft ace and player blackjack:
  - Player cards 1 and 10, dealer cards 10 and 7.
  - Required: o_playerTotal = 21, o_turnIndicator never asserts, dealer stands at 17, o_result = 1 (win).
- Dealer draws on 16:
  - Cards P=10, D=10, P=9, D=6; STAND; the dealer card is held back by i_cardValid for 5 cycles, then 10 is delivered.
  - Required: o_cardReq stays high for exactly those cycles, dealer total 26, o_result = 1 (win).
- Deck handshake and ignored inputs:
  - Stimulus: i_cardValid pulses while o_cardReq is low; i_ready with COMMAND_NONE in PLAYER_TURN; a deal pulse during PLAYER_TURN.
  - Required: totals and state unchanged.
- Reset mid-handshake:
  - Drop i_rst_n while o_cardReq is high in DEAL_D1.
  - Required: all outputs are 0 immediately; after release, the state is IDLE and no request is pending.
